// File: rtl/ifmap_stream_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module   : ifmap_stream_pkg                                           |
// | Purpose  : Shared types and constants for the ifmap stream controller |
// |            (FSM state enum, byte-lane selects, push-mode encodings).  |
// | Contents : state_e, LANE_B0..LANE_B3, PUSH_BYTE / PUSH_WORD           |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package ifmap_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_POP  = 2'd2,
      ST_WAIT = 2'd3
   } state_e;

   // Byte lane of a GLB word, taken from the low address bits.
   localparam logic [1:0] LANE_B0 = 2'd0;   // bits  7:0
   localparam logic [1:0] LANE_B1 = 2'd1;   // bits 15:8
   localparam logic [1:0] LANE_B2 = 2'd2;   // bits 23:16
   localparam logic [1:0] LANE_B3 = 2'd3;   // bits 31:24

   // FIFO entry kind carried on push_mod_o.
   localparam logic PUSH_BYTE = 1'b0;
   localparam logic PUSH_WORD = 1'b1;

endpackage : ifmap_stream_pkg
`default_nettype wire

// File: rtl/ifmap_stream_ctrl_lane_sel.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module   : ifmap_lane_sel                                             |
// | Purpose  : Holds the element issued in the previous cycle (pad flag,  |
// |            byte lane, entry mode) and forms the FIFO push from the    |
// |            GLB read word that arrives one cycle after the grant.      |
// | Ports    : clk, rst_n      - clock, async active-low reset            |
// |            flush_i         - drops the held element                   |
// |            issue_i         - an element was issued this cycle         |
// |            pad_i, mode_i,  - attributes of the issued element         |
// |            lane_i                                                     |
// |            glb_rdata_i     - GLB read word                            |
// |            inflight_o      - a push is pending for this cycle         |
// |            push_o, push_mod_o, push_data_o - FIFO push interface      |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module ifmap_lane_sel
   import ifmap_stream_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush_i,
   input  logic        issue_i,
   input  logic        pad_i,
   input  logic        mode_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] glb_rdata_i,
   output logic        inflight_o,
   output logic        push_o,
   output logic        push_mod_o,
   output logic [31:0] push_data_o
);

   logic       valid_q;
   logic       pad_q;
   logic       mode_q;
   logic [1:0] lane_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         pad_q   <= 1'b0;
         mode_q  <= PUSH_BYTE;
         lane_q  <= LANE_B0;
      end else begin
         valid_q <= issue_i && !flush_i;
         if (issue_i) begin
            pad_q  <= pad_i;
            mode_q <= mode_i;
            lane_q <= lane_i;
         end
      end
   end

   assign inflight_o = valid_q;
   // A flush arriving while the data is on the bus discards it.
   assign push_o     = valid_q && !flush_i;
   assign push_mod_o = push_o && (mode_q == PUSH_WORD);

   always_comb begin
      push_data_o = 32'd0;
      if (push_o && !pad_q) begin
         if (mode_q == PUSH_WORD) begin
            push_data_o = glb_rdata_i;
         end else begin
            case (lane_q)
               LANE_B0: push_data_o = {24'd0, glb_rdata_i[7:0]};
               LANE_B1: push_data_o = {24'd0, glb_rdata_i[15:8]};
               LANE_B2: push_data_o = {24'd0, glb_rdata_i[23:16]};
               LANE_B3: push_data_o = {24'd0, glb_rdata_i[31:24]};
               default: push_data_o = 32'd0;
            endcase
         end
      end
   end

endmodule : ifmap_lane_sel
`default_nettype wire

// File: rtl/ifmap_stream_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module   : ifmap_stream_ctrl                                          |
// | Purpose  : ifmap FIFO controller between the GLB read arbiter and the |
// |            PE-array ifmap FIFO. Produces padded rows (local zero pads,|
// |            real pixels read from GLB), then pops a per-task count of  |
// |            entries to the PE array.                                   |
// | Build    : IFMAP_BURST_EN - when defined, aligned runs of 4 real      |
// |            pixels are fetched and pushed as one word entry.           |
// | Ports    : row config  in_c_i, pad_l_i, pad_r_i, base_addr_i          |
// |            task ctrl   start_i, pop_num_i, flush_i, done_o, is_pop_o  |
// |            GLB side    glb_busy_i, permit_i, glb_rdata_i,             |
// |                        read_req_o, glb_addr_o                         |
// |            FIFO side   fifo_full_i, fifo_empty_i, fifo_free_i,        |
// |                        push_o, push_data_o, push_mod_o, pop_o         |
// |            PE side     pe_move_i                                      |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module ifmap_stream_ctrl
   import ifmap_stream_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int C_W    = 16,
   parameter int PAD_W  = 2,
   parameter int FREE_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [C_W-1:0]    in_c_i,
   input  logic [PAD_W-1:0]  pad_l_i,
   input  logic [PAD_W-1:0]  pad_r_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic              start_i,
   input  logic [31:0]       pop_num_i,
   input  logic              flush_i,
   input  logic              glb_busy_i,
   input  logic              permit_i,
   input  logic [31:0]       glb_rdata_i,
   input  logic              fifo_full_i,
   input  logic              fifo_empty_i,
   input  logic [FREE_W-1:0] fifo_free_i,
   input  logic              pe_move_i,
   output logic              read_req_o,
   output logic [ADDR_W-1:0] glb_addr_o,
   output logic              push_o,
   output logic [31:0]       push_data_o,
   output logic              push_mod_o,
   output logic              pop_o,
   output logic              is_pop_o,
   output logic              done_o
);

   localparam int CNT_W = C_W + 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  elem_cnt_q, elem_cnt_d;
   logic [ADDR_W-1:0] read_ptr_q, read_ptr_d;
   logic [31:0]       pop_cnt_q, pop_cnt_d;
   logic [31:0]       pop_num_q, pop_num_d;

   logic [CNT_W-1:0]  w_total;
   logic [CNT_W-1:0]  w_real_lo;
   logic [CNT_W-1:0]  w_real_hi;
   logic              w_pending;
   logic              w_is_pad;
   logic              w_inflight;
   logic              w_room;
   logic              w_fill;
   logic              w_pad_issue;
   logic              w_grant;
   logic              w_word;
   logic [2:0]        w_step;
   logic              w_last_pop;

   // ---------------- row bookkeeping ----------------
   assign w_total   = CNT_W'(in_c_i) + CNT_W'(pad_l_i) + CNT_W'(pad_r_i);
   assign w_real_lo = CNT_W'(pad_l_i);
   assign w_real_hi = CNT_W'(pad_l_i) + CNT_W'(in_c_i);
   assign w_pending = (elem_cnt_q < w_total);
   assign w_is_pad  = (elem_cnt_q < w_real_lo) || (elem_cnt_q >= w_real_hi);

   // The pending push (if any) still needs a FIFO slot, so issue only
   // when more slots are free than are already spoken for.
   assign w_room = !fifo_full_i && (fifo_free_i > FREE_W'(w_inflight));
   assign w_fill = (state_q == ST_FILL);

   assign w_pad_issue = w_fill && w_pending && w_is_pad && w_room && !flush_i;
   assign read_req_o  = w_fill && w_pending && !w_is_pad && w_room;
   assign w_grant     = read_req_o && permit_i && !flush_i;

   assign glb_addr_o = base_addr_i + read_ptr_q;

`ifdef IFMAP_BURST_EN
   // Word fetch only from a 4-byte boundary of the row and only while at
   // least four real pixels remain; read_req_o already excludes pads.
   assign w_word = (read_ptr_q[1:0] == 2'b00) &&
                   ((w_real_hi - elem_cnt_q) >= CNT_W'(4));
`else
   assign w_word = 1'b0;
`endif

   assign w_step = w_word ? 3'd4 : 3'd1;

   always_comb begin
      elem_cnt_d = elem_cnt_q;
      read_ptr_d = read_ptr_q;
      if (flush_i) begin
         elem_cnt_d = '0;
         read_ptr_d = '0;
      end else if (w_pad_issue) begin
         elem_cnt_d = elem_cnt_q + CNT_W'(1);
      end else if (w_grant) begin
         elem_cnt_d = elem_cnt_q + CNT_W'(w_step);
         read_ptr_d = read_ptr_q + ADDR_W'(w_step);
      end
   end

   // ---------------- push path ----------------
   ifmap_lane_sel u_lane_sel (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .issue_i     (w_pad_issue || w_grant),
      .pad_i       (w_pad_issue),
      .mode_i      (w_word ? PUSH_WORD : PUSH_BYTE),
      .lane_i      (glb_addr_o[1:0]),
      .glb_rdata_i (glb_rdata_i),
      .inflight_o  (w_inflight),
      .push_o      (push_o),
      .push_mod_o  (push_mod_o),
      .push_data_o (push_data_o)
   );

   // ---------------- pop path and FSM ----------------
   assign pop_o      = (state_q == ST_POP) && !fifo_empty_i && pe_move_i;
   assign w_last_pop = (pop_cnt_q == (pop_num_q - 32'd1));

   always_comb begin
      state_d   = state_q;
      pop_cnt_d = pop_cnt_q;
      pop_num_d = pop_num_q;
      if (flush_i) begin
         state_d   = ST_IDLE;
         pop_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i && (pop_num_i != 32'd0)) begin
                  pop_num_d = pop_num_i;
                  pop_cnt_d = '0;
                  state_d   = fifo_empty_i ? ST_FILL : ST_POP;
               end
            end
            ST_FILL: begin
               if (fifo_full_i || (!w_pending && !w_inflight)) begin
                  state_d = glb_busy_i ? ST_WAIT : ST_POP;
               end
            end
            ST_POP: begin
               if (pop_o) begin
                  pop_cnt_d = pop_cnt_q + 32'd1;
               end
               if (pop_o && w_last_pop) begin
                  state_d   = ST_IDLE;
                  pop_cnt_d = '0;
               end else if (fifo_empty_i && w_pending) begin
                  state_d = ST_FILL;
               end else if (glb_busy_i) begin
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!glb_busy_i) begin
                  state_d = ST_POP;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         elem_cnt_q <= '0;
         read_ptr_q <= '0;
         pop_cnt_q  <= '0;
         pop_num_q  <= '0;
         done_o     <= 1'b1;
         is_pop_o   <= 1'b0;
      end else begin
         state_q    <= state_d;
         elem_cnt_q <= elem_cnt_d;
         read_ptr_q <= read_ptr_d;
         pop_cnt_q  <= pop_cnt_d;
         pop_num_q  <= pop_num_d;
         done_o     <= (state_d == ST_IDLE);
         is_pop_o   <= (state_d == ST_POP);
      end
   end

endmodule : ifmap_stream_ctrl
`default_nettype wire

// File: tb/tb_ifmap_stream_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module   : tb_ifmap_stream_ctrl                                       |
// | Purpose  : Self-checking bench for ifmap_stream_ctrl. A GLB model,    |
// |            a FIFO occupancy model and a row-level reference (list of  |
// |            expected pushes / read addresses) are kept here.           |
// | Build    : IFMAP_BURST_EN changes the expected row entries.           |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_ifmap_stream_ctrl;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] in_c_i = '0;
   logic [1:0]  pad_l_i = '0, pad_r_i = '0;
   logic [31:0] base_addr_i = '0;
   logic        start_i = 1'b0;
   logic [31:0] pop_num_i = '0;
   logic        flush_i = 1'b0, glb_busy_i = 1'b0, permit_i = 1'b0;
   logic [31:0] glb_rdata_i = '0;
   logic        fifo_full_i = 1'b0, fifo_empty_i = 1'b1;
   logic [4:0]  fifo_free_i = 5'd16;
   logic        pe_move_i = 1'b0;
   logic        read_req_o, push_o, push_mod_o, pop_o, is_pop_o, done_o;
   logic [31:0] glb_addr_o, push_data_o;

   always #5 clk = ~clk;

   ifmap_stream_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_c_i(in_c_i), .pad_l_i(pad_l_i),
      .pad_r_i(pad_r_i), .base_addr_i(base_addr_i), .start_i(start_i),
      .pop_num_i(pop_num_i), .flush_i(flush_i), .glb_busy_i(glb_busy_i),
      .permit_i(permit_i), .glb_rdata_i(glb_rdata_i), .fifo_full_i(fifo_full_i),
      .fifo_empty_i(fifo_empty_i), .fifo_free_i(fifo_free_i), .pe_move_i(pe_move_i),
      .read_req_o(read_req_o), .glb_addr_o(glb_addr_o), .push_o(push_o),
      .push_data_o(push_data_o), .push_mod_o(push_mod_o), .pop_o(pop_o),
      .is_pop_o(is_pop_o), .done_o(done_o)
   );

   int total_cnt = 0;
   int bad_cnt   = 0;

   // environment state
   int          fifo_cnt = 0;
   int          permit_pct = 100, pe_pct = 100, busy_pct = 0;
   bit          pe_toggle = 0, busy_force = 0;
   int          pops = 0, overflow = 0, underflow = 0;
   logic [7:0]  seed;
   logic [31:0] rdata_nxt = '0;
   logic [32:0] got_push[$], exp_push[$];
   logic [31:0] got_addr[$], exp_addr[$];
   // last observed outputs
   logic        s_req, s_push, s_mod, s_pop, s_ispop, s_done;
   logic [31:0] s_addr, s_data;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [31:0] t;
      t = a * 32'd29;
      return t[7:0] ^ t[15:8] ^ seed;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] a4;
      a4 = {a[31:2], 2'b00};
      return {mem_byte(a4 + 3), mem_byte(a4 + 2), mem_byte(a4 + 1), mem_byte(a4)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      assert (got === exp) else begin
         bad_cnt++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, let the
   // combinational outputs settle, observe, update the environment models.
   task automatic cycle(input bit st, input bit fl);
      bit pu, po;
      @(negedge clk);
      start_i      = st;
      flush_i      = fl;
      glb_rdata_i  = rdata_nxt;
      fifo_full_i  = (fifo_cnt >= DEPTH);
      fifo_empty_i = (fifo_cnt == 0);
      fifo_free_i  = 5'(DEPTH - fifo_cnt);
      if (pe_toggle) pe_move_i = !pe_move_i;
      else           pe_move_i = ($urandom_range(99) < pe_pct);
      glb_busy_i = busy_force || ($urandom_range(99) < busy_pct);
      #1;
      permit_i = read_req_o && ($urandom_range(99) < permit_pct);
      #1;
      s_req = read_req_o; s_push = push_o; s_mod = push_mod_o; s_pop = pop_o;
      s_ispop = is_pop_o; s_done = done_o; s_addr = glb_addr_o; s_data = push_data_o;
      pu = push_o; po = pop_o;
      if (pu) got_push.push_back({push_mod_o, push_data_o});
      if (po) pops++;
      if (pu && fifo_cnt >= DEPTH) overflow++;
      if (po && fifo_cnt == 0) underflow++;
      fifo_cnt = fifo_cnt + int'(pu) - int'(po && fifo_cnt > 0);
      if (read_req_o && permit_i) begin
         got_addr.push_back(glb_addr_o);
         rdata_nxt = mem_word(glb_addr_o);
      end else begin
         rdata_nxt = $urandom;
      end
   endtask

   task automatic config_row(input int c, input int pl, input int pr, input logic [31:0] base);
      in_c_i = 16'(c); pad_l_i = 2'(pl); pad_r_i = 2'(pr); base_addr_i = base;
   endtask

   // Reference: the row as a list of FIFO entries and GLB read addresses.
   task automatic build_expected(input int c, input int pl, input int pr, input logic [31:0] base);
      int k, j;
      bit word_ok;
      exp_push.delete(); exp_addr.delete();
      k = 0;
      while (k < c + pl + pr) begin
         if (k < pl || k >= pl + c) begin
            exp_push.push_back(33'd0);
            k++;
         end else begin
            j = k - pl;
            word_ok = 0;
`ifdef IFMAP_BURST_EN
            word_ok = (j % 4 == 0) && (c - j >= 4);
`endif
            if (word_ok) begin
               exp_push.push_back({1'b1, mem_word(base + 32'(j))});
               k += 4;
            end else begin
               exp_push.push_back({1'b0, 24'd0, mem_byte(base + 32'(j))});
               k++;
            end
            exp_addr.push_back(base + 32'(j));
         end
      end
   endtask

   task automatic run_row(input string nm, input int c, input int pl, input int pr,
                          input logic [31:0] base, input int perm, input int pe, input int busy);
      int n;
      config_row(c, pl, pr, base);
      build_expected(c, pl, pr, base);
      permit_pct = perm; pe_pct = pe; busy_pct = busy; pe_toggle = 0; busy_force = 0;
      fifo_cnt = 0;
      cycle(0, 1);
      got_push.delete(); got_addr.delete(); pops = 0; overflow = 0; underflow = 0;
      pop_num_i = 32'(exp_push.size());
      cycle(1, 0);
      n = 0;
      do begin
         cycle(0, 0);
         n++;
      end while (!s_done && n < 800);
      chk({nm, "_done"}, 64'(s_done), 64'd1);
      chk({nm, "_npush"}, 64'(got_push.size()), 64'(exp_push.size()));
      chk({nm, "_nreq"}, 64'(got_addr.size()), 64'(exp_addr.size()));
      for (int i = 0; i < exp_push.size(); i++)
         if (i < got_push.size()) chk($sformatf("%s_push%0d", nm, i), 64'(got_push[i]), 64'(exp_push[i]));
      for (int i = 0; i < exp_addr.size(); i++)
         if (i < got_addr.size()) chk($sformatf("%s_addr%0d", nm, i), 64'(got_addr[i]), 64'(exp_addr[i]));
      chk({nm, "_pops"}, 64'(pops), 64'(exp_push.size()));
      chk({nm, "_ovf_unf"}, 64'(overflow + underflow), 64'd0);
   endtask

   initial begin
      logic [31:0] b;
      int n, last_i;
      seed = 8'($urandom);

      // ---- reset state ----
      base_addr_i = 32'h100;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_done", 64'(done_o), 64'd1);
      chk("rst_req", 64'(read_req_o), 64'd0);
      chk("rst_push", 64'(push_o), 64'd0);
      chk("rst_mod", 64'(push_mod_o), 64'd0);
      chk("rst_pop", 64'(pop_o), 64'd0);
      chk("rst_ispop", 64'(is_pop_o), 64'd0);
      chk("rst_data", 64'(push_data_o), 64'd0);
      chk("rst_addr", 64'(glb_addr_o), 64'h100);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // ---- directed rows ----
      run_row("row_pad", 8, 1, 1, 32'h100, 100, 100, 0);
      run_row("row_nopad", 8, 0, 0, 32'h200, 100, 100, 0);

      // ---- permit withheld: request holds, address stable ----
      b = 32'h0000_3a5;
      config_row(8, 0, 0, b);
      permit_pct = 0; pe_pct = 0; busy_pct = 0; fifo_cnt = 0;
      cycle(0, 1);
      pop_num_i = 32'd8;
      cycle(1, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0);
         chk($sformatf("hold_req%0d", i), 64'(s_req), 64'd1);
         chk($sformatf("hold_push%0d", i), 64'(s_push), 64'd0);
         chk($sformatf("hold_addr%0d", i), 64'(s_addr), 64'(b));
      end
      permit_pct = 100;
      cycle(0, 0);
      cycle(0, 0);
      chk("hold_rel_push", 64'(s_push), 64'd1);
      chk("hold_rel_data", 64'(s_data), 64'(mem_byte(b)));

      // ---- pop sequencing: 6 pops out of a FIFO holding 10 ----
      fifo_cnt = 10; permit_pct = 100; pe_toggle = 1; pe_move_i = 1'b0;
      cycle(0, 1);
      fifo_cnt = 10; pops = 0; last_i = -1;
      pop_num_i = 32'd6;
      cycle(1, 0);
      for (int i = 0; i < 30; i++) begin
         cycle(0, 0);
         if (last_i >= 0 && i == last_i + 1) chk("pop_done_next", 64'(s_done), 64'd1);
         if (s_pop && pops == 6 && last_i < 0) last_i = i;
      end
      chk("pop_count", 64'(pops), 64'd6);
      chk("pop_final_seen", 64'(last_i >= 0), 64'd1);
      chk("pop_fifo_left", 64'(fifo_cnt), 64'd4);
      pe_toggle = 0;

      // ---- busy when the FIFO fills: WAIT until busy drops ----
      config_row(12, 3, 3, 32'h400);
      fifo_cnt = 0; permit_pct = 100; pe_pct = 100; busy_pct = 0; busy_force = 1;
      cycle(0, 1);
      pop_num_i = 32'd18;
      cycle(1, 0);
      n = 0;
      while (fifo_cnt < DEPTH && n < 60) begin
         cycle(0, 0);
         n++;
      end
      chk("busy_filled", 64'(fifo_cnt), 64'(DEPTH));
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0);
         chk($sformatf("busy_nopop%0d", i), 64'(s_pop), 64'd0);
         chk($sformatf("busy_notpop%0d", i), 64'(s_ispop), 64'd0);
      end
      busy_force = 0;
      cycle(0, 0);
      cycle(0, 0);
      chk("busy_ispop", 64'(s_ispop), 64'd1);
      chk("busy_pop", 64'(s_pop), 64'd1);

      // ---- flush the cycle after a grant ----
      b = 32'h0000_0b12;
      config_row(4, 0, 0, b);
      fifo_cnt = 0; permit_pct = 100; pe_pct = 0;
      cycle(0, 1);
      got_addr.delete();
      pop_num_i = 32'd4;
      cycle(1, 0);
      n = 0;
      while (got_addr.size() == 0 && n < 10) begin
         cycle(0, 0);
         n++;
      end
      chk("flush_granted", 64'(got_addr.size()), 64'd1);
      cycle(0, 1);
      chk("flush_nopush", 64'(s_push), 64'd0);
      cycle(0, 0);
      chk("flush_idle", 64'(s_done), 64'd1);
      chk("flush_addr", 64'(s_addr), 64'(b));
      chk("flush_noreq", 64'(s_req), 64'd0);

      // ---- randomized rows ----
      for (int r = 0; r < 8; r++) begin
         b = $urandom;
`ifdef IFMAP_BURST_EN
         b[1:0] = 2'b00;
`endif
         run_row($sformatf("rnd%0d", r), int'($urandom_range(1, 12)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), b, int'($urandom_range(30, 100)),
                 int'($urandom_range(30, 100)), int'($urandom_range(0, 30)));
      end

      // ---- reset in the middle of a task ----
      b = 32'h0000_0777;
      config_row(10, 2, 1, b);
      fifo_cnt = 0; permit_pct = 100; pe_pct = 0; busy_pct = 0;
      cycle(0, 1);
      pop_num_i = 32'd13;
      cycle(1, 0);
      repeat (4) cycle(0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_done", 64'(done_o), 64'd1);
      chk("mrst_req", 64'(read_req_o), 64'd0);
      chk("mrst_push", 64'(push_o), 64'd0);
      chk("mrst_addr", 64'(glb_addr_o), 64'(b));
      @(negedge clk) rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule : tb_ifmap_stream_ctrl
`default_nettype wire
